// File: rtl/e203_thread_pc_bank_pkg.sv
// Shared definitions for the per-thread PC bank.
//   - FSM state encodings (2 bits) for the PC bank switch sequencer
//   - default reset PC of thread 1
//   - one-hot thread vector to index conversion, shared by per-thread banks
package e203_thread_pc_bank_pkg;

    localparam logic [1:0] E203_TPB_IDLE     = 2'd0;
    localparam logic [1:0] E203_TPB_DRAIN    = 2'd1;
    localparam logic [1:0] E203_TPB_REDIRECT = 2'd2;

    localparam logic [31:0] E203_TPB_THREAD1_BOOT_PC = 32'h8000_0100;

    // Lowest set bit wins; an all-zero vector maps to thread 0.
    function automatic logic e203_oh2idx(input logic [1:0] oh);
        return oh[0] ? 1'b0 : oh[1];
    endfunction

endpackage

// File: rtl/e203_thread_pc_bank_if.sv
// Signal bundle between the context-switch controller / IFU side and the
// thread PC bank.
//   master : controller + IFU side (drives switch request, fetch status,
//            PC writes, redirect ready)
//   slave  : the PC bank (drives redirect request and ifetch_wait)
interface e203_thread_pc_bank_if #(
    parameter int unsigned THREADS_NUM = 2,
    parameter int unsigned PC_SIZE     = 32
);
    logic                   switch_en;
    logic [THREADS_NUM-1:0] thread_sel;
    logic [THREADS_NUM-1:0] thread_sel_next;
    logic [PC_SIZE-1:0]     ifu_cur_pc;
    logic                   ifu_rsp_pending;
    logic                   pc_wr_en;
    logic [THREADS_NUM-1:0] pc_wr_tid;
    logic [PC_SIZE-1:0]     pc_wr_data;
    logic                   redirect_vld;
    logic                   redirect_rdy;
    logic [PC_SIZE-1:0]     redirect_pc;
    logic                   ifetch_wait;

    modport master (
        output switch_en, thread_sel, thread_sel_next, ifu_cur_pc,
               ifu_rsp_pending, pc_wr_en, pc_wr_tid, pc_wr_data, redirect_rdy,
        input  redirect_vld, redirect_pc, ifetch_wait
    );

    modport slave (
        input  switch_en, thread_sel, thread_sel_next, ifu_cur_pc,
               ifu_rsp_pending, pc_wr_en, pc_wr_tid, pc_wr_data, redirect_rdy,
        output redirect_vld, redirect_pc, ifetch_wait
    );
endinterface

// File: rtl/e203_thread_pc_regfile.sv
// Per-thread saved-PC bank: THREADS_NUM entries of PC_SIZE bits.
//   cap_en/cap_idx/cap_pc : resume-PC capture of the outgoing thread
//   wr_en/wr_idx/wr_pc    : software/debug write
//   rd_idx/rd_pc          : read port, forwards a same-cycle write
// Bit 0 of every stored PC is zero. Capture beats a write to the same entry.
module e203_thread_pc_regfile #(
    parameter int unsigned        THREADS_NUM     = 2,
    parameter int unsigned        PC_SIZE         = 32,
    parameter logic [PC_SIZE-1:0] THREAD1_BOOT_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_en,
    input  logic               cap_idx,
    input  logic [PC_SIZE-1:0] cap_pc,
    input  logic               wr_en,
    input  logic               wr_idx,
    input  logic [PC_SIZE-1:0] wr_pc,
    input  logic               rd_idx,
    output logic [PC_SIZE-1:0] rd_pc
);
    localparam logic [PC_SIZE-1:0] PC_MASK = {{(PC_SIZE-1){1'b1}}, 1'b0};

    logic [PC_SIZE-1:0] bank_q [THREADS_NUM];
    logic [PC_SIZE-1:0] bank_d [THREADS_NUM];

    always_comb begin
        for (int unsigned i = 0; i < THREADS_NUM; i++) begin
            bank_d[i] = bank_q[i];
            if (cap_en && (32'(cap_idx) == i)) begin
                bank_d[i] = cap_pc & PC_MASK;
            end else if (wr_en && (32'(wr_idx) == i)) begin
                bank_d[i] = wr_pc & PC_MASK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < THREADS_NUM; i++) begin
                bank_q[i] <= (i == 1) ? THREAD1_BOOT_PC : '0;
            end
        end else begin
            for (int unsigned i = 0; i < THREADS_NUM; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Forward a write landing on the entry being read this cycle.
    always_comb begin
        rd_pc = bank_q[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_pc = wr_pc & PC_MASK;
        end
    end

endmodule

// File: rtl/e203_thread_pc_bank.sv
// Thread PC bank and switch sequencer.
// On a switch request it saves the outgoing thread's resume PC, waits for
// outstanding IFU fetches to drain, then redirects the IFU to the incoming
// thread's saved PC. ifetch_wait is high for the whole sequence.
//   clk, rst_n  : core clock, asynchronous active-low reset
//   bus (slave) : switch request, IFU status, PC writes, redirect handshake
//   switch_cnt  : saturating count of completed switches
module e203_thread_pc_bank
    import e203_thread_pc_bank_pkg::*;
#(
    parameter int unsigned        THREADS_NUM     = 2,
    parameter int unsigned        PC_SIZE         = 32,
    parameter logic [PC_SIZE-1:0] THREAD1_BOOT_PC = E203_TPB_THREAD1_BOOT_PC,
    parameter int unsigned        CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e203_thread_pc_bank_if.slave bus,
    output logic [CNT_W-1:0]     switch_cnt
);
    logic [1:0]         state_q, state_d;
    logic               tgt_q, tgt_d;
    logic [PC_SIZE-1:0] redirect_pc_q, redirect_pc_d;
    logic               redirect_vld_q, redirect_vld_d;
    logic [CNT_W-1:0]   switch_cnt_q, switch_cnt_d;

    logic               cap_en;
    logic [PC_SIZE-1:0] rd_pc;

    e203_thread_pc_regfile #(
        .THREADS_NUM     (THREADS_NUM),
        .PC_SIZE         (PC_SIZE),
        .THREAD1_BOOT_PC (THREAD1_BOOT_PC)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap_en  (cap_en),
        .cap_idx (e203_oh2idx(bus.thread_sel)),
        .cap_pc  (bus.ifu_cur_pc),
        .wr_en   (bus.pc_wr_en),
        .wr_idx  (e203_oh2idx(bus.pc_wr_tid)),
        .wr_pc   (bus.pc_wr_data),
        .rd_idx  (tgt_q),
        .rd_pc   (rd_pc)
    );

    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_vld_d = redirect_vld_q;
        switch_cnt_d   = switch_cnt_q;
        cap_en         = 1'b0;
        case (state_q)
            E203_TPB_IDLE: begin
                if (bus.switch_en) begin
                    cap_en  = 1'b1;
                    tgt_d   = e203_oh2idx(bus.thread_sel_next);
                    state_d = E203_TPB_DRAIN;
                end
            end
            E203_TPB_DRAIN: begin
                if (!bus.ifu_rsp_pending) begin
                    redirect_pc_d  = rd_pc;
                    redirect_vld_d = 1'b1;
                    state_d        = E203_TPB_REDIRECT;
                end
            end
            E203_TPB_REDIRECT: begin
                if (redirect_vld_q && bus.redirect_rdy) begin
                    redirect_vld_d = 1'b0;
                    if (switch_cnt_q != '1) begin
                        switch_cnt_d = switch_cnt_q + CNT_W'(1);
                    end
                    state_d = E203_TPB_IDLE;
                end
            end
            default: state_d = E203_TPB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= E203_TPB_IDLE;
            tgt_q          <= 1'b0;
            redirect_pc_q  <= '0;
            redirect_vld_q <= 1'b0;
            switch_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            redirect_pc_q  <= redirect_pc_d;
            redirect_vld_q <= redirect_vld_d;
            switch_cnt_q   <= switch_cnt_d;
        end
    end

    assign bus.redirect_vld = redirect_vld_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.ifetch_wait  = (state_q != E203_TPB_IDLE);
    assign switch_cnt       = switch_cnt_q;

    // The controller gates switch_en with ifetch_wait, so a request while a
    // switch is in flight indicates an upstream problem; it is dropped.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.switch_en && state_q != E203_TPB_IDLE))
                else $warning("switch_en ignored while a switch is in progress");
            assert (!(bus.switch_en && state_q == E203_TPB_IDLE) ||
                    ($onehot(bus.thread_sel) && $onehot(bus.thread_sel_next)))
                else $error("thread_sel/thread_sel_next not one-hot");
            assert (!bus.pc_wr_en || $onehot(bus.pc_wr_tid))
                else $error("pc_wr_tid not one-hot");
        end
    end

endmodule

// File: tb/tb_e203_thread_pc_bank.sv
module tb_e203_thread_pc_bank;
    localparam logic [31:0] BOOT1 = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] switch_cnt;
    logic [1:0]  switch_cnt_s;

    int checks = 0;
    int failures = 0;

    // Reference model: saved PCs and number of completed switches.
    logic [31:0] bank_m [2];
    int          cnt_m;

    always #5 clk = ~clk;

    e203_thread_pc_bank_if #(.THREADS_NUM(2), .PC_SIZE(32)) bus ();
    e203_thread_pc_bank_if #(.THREADS_NUM(2), .PC_SIZE(32)) bus_s ();

    e203_thread_pc_bank #(
        .THREADS_NUM(2), .PC_SIZE(32), .THREAD1_BOOT_PC(BOOT1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .switch_cnt(switch_cnt)
    );

    // Narrow-counter copy fed the same stimulus, used to reach saturation.
    e203_thread_pc_bank #(
        .THREADS_NUM(2), .PC_SIZE(32), .THREAD1_BOOT_PC(BOOT1), .CNT_W(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .switch_cnt(switch_cnt_s)
    );

    assign bus_s.switch_en       = bus.switch_en;
    assign bus_s.thread_sel      = bus.thread_sel;
    assign bus_s.thread_sel_next = bus.thread_sel_next;
    assign bus_s.ifu_cur_pc      = bus.ifu_cur_pc;
    assign bus_s.ifu_rsp_pending = bus.ifu_rsp_pending;
    assign bus_s.pc_wr_en        = bus.pc_wr_en;
    assign bus_s.pc_wr_tid       = bus.pc_wr_tid;
    assign bus_s.pc_wr_data      = bus.pc_wr_data;
    assign bus_s.redirect_rdy    = bus.redirect_rdy;

    function automatic logic [1:0] oh(input int t);
        return (t == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic idle_inputs();
        bus.switch_en       = 1'b0;
        bus.pc_wr_en        = 1'b0;
        bus.ifu_rsp_pending = 1'b0;
        bus.redirect_rdy    = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.thread_sel      = 2'b01;
        bus.thread_sel_next = 2'b10;
        bus.ifu_cur_pc      = '0;
        bus.pc_wr_tid       = 2'b01;
        bus.pc_wr_data      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bank_m[0] = '0;
        bank_m[1] = BOOT1;
        cnt_m = 0;
        @(negedge clk);
    endtask

    // Reference: capture at cycle 0, target read at cycle r, redirect seen one
    // cycle later; a write at cycle w lands before the read when w <= r, and a
    // same-cycle capture of the same entry overrides it.
    task automatic model_switch(input int from, input int to, input logic [31:0] pc,
                                input int pend, input int wr_at, input int wr_tid,
                                input logic [31:0] wr_data,
                                output logic [31:0] exp_pc, output int exp_vld);
        int r;
        r = (pend > 1) ? pend : 1;
        exp_vld = r + 1;
        if (wr_at == 0) bank_m[wr_tid] = wr_data & ~32'd1;
        bank_m[from] = pc & ~32'd1;
        if (wr_at >= 1 && wr_at <= r) bank_m[wr_tid] = wr_data & ~32'd1;
        exp_pc = bank_m[to];
        if (wr_at > r) bank_m[wr_tid] = wr_data & ~32'd1;
        cnt_m++;
    endtask

    // Runs one switch; called and returns just after a falling edge.
    task automatic drive_switch(input int from, input int to, input logic [31:0] pc,
                                input int pend, input int stall, input int wr_at,
                                input int wr_tid, input logic [31:0] wr_data, input bit glitch,
                                output int vld_cyc, output logic [31:0] rpc,
                                output bit stable, output bit wait_ok);
        int  hs_cyc;
        bit  done;
        vld_cyc = -1; hs_cyc = -1; done = 0;
        rpc = '0; stable = 1; wait_ok = 1;
        bus.thread_sel      = oh(from);
        bus.thread_sel_next = oh(to);
        bus.ifu_cur_pc      = pc;
        bus.switch_en       = 1'b1;
        bus.ifu_rsp_pending = (pend > 0);
        bus.redirect_rdy    = (stall == 0);
        bus.pc_wr_tid       = oh(wr_tid);
        bus.pc_wr_data      = wr_data;
        bus.pc_wr_en        = (wr_at == 0);
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (hs_cyc >= 0) begin
                if (bus.ifetch_wait !== 1'b0 || bus.redirect_vld !== 1'b0) wait_ok = 0;
                done = 1;
            end else begin
                if (bus.ifetch_wait !== 1'b1) wait_ok = 0;
                if (bus.redirect_vld === 1'b1) begin
                    if (vld_cyc < 0) begin
                        vld_cyc = k;
                        rpc = bus.redirect_pc;
                    end else if (bus.redirect_pc !== rpc) begin
                        stable = 0;
                    end
                end
                bus.switch_en       = glitch && (k == 1);
                if (glitch && k == 1) begin
                    bus.thread_sel = oh(to);
                    bus.ifu_cur_pc = pc ^ 32'h0055_5500;
                end
                bus.ifu_rsp_pending = (k < pend);
                bus.pc_wr_en        = (wr_at == k);
                bus.redirect_rdy    = (vld_cyc >= 0) ? ((k - vld_cyc) >= stall) : (stall == 0);
                if (vld_cyc >= 0 && bus.redirect_rdy) hs_cyc = k;
            end
        end
        if (!done) wait_ok = 0;
        idle_inputs();
    endtask

    task automatic test_reset();
        checks++; if (bus.redirect_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", bus.redirect_vld); end
        checks++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", bus.redirect_pc); end
        checks++; if (bus.ifetch_wait !== 1'b0) begin failures++; $display("FAIL reset_wait got=%b want=0", bus.ifetch_wait); end
        checks++; if (switch_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0", switch_cnt); end
        checks++; if (dut.u_regfile.bank_q[0] !== 32'h0) begin failures++; $display("FAIL reset_bank0 got=%h want=0", dut.u_regfile.bank_q[0]); end
        checks++; if (dut.u_regfile.bank_q[1] !== BOOT1) begin failures++; $display("FAIL reset_bank1 got=%h want=%h", dut.u_regfile.bank_q[1], BOOT1); end
    endtask

    task automatic test_basic();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        model_switch(0, 1, 32'h8000_0040, 0, -1, 0, 0, epc, ev);
        drive_switch(0, 1, 32'h8000_0040, 0, 0, -1, 0, 0, 0, v, rpc, st, wo);
        checks++; if (v != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", v); end
        checks++; if (rpc !== 32'h8000_0100) begin failures++; $display("FAIL basic_pc got=%h want=80000100", rpc); end
        checks++; if (dut.u_regfile.bank_q[0] !== 32'h8000_0040) begin failures++; $display("FAIL basic_bank0 got=%h want=80000040", dut.u_regfile.bank_q[0]); end
        checks++; if (switch_cnt !== 16'd1) begin failures++; $display("FAIL basic_cnt got=%0d want=1", switch_cnt); end
        checks++; if (!wo) begin failures++; $display("FAIL basic_wait got=0 want=1"); end
    endtask

    task automatic test_drain_backpressure();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        model_switch(1, 0, 32'h0000_1000, 5, -1, 0, 0, epc, ev);
        drive_switch(1, 0, 32'h0000_1000, 5, 3, -1, 0, 0, 0, v, rpc, st, wo);
        checks++; if (v != 6) begin failures++; $display("FAIL drain_latency got=%0d want=6", v); end
        checks++; if (rpc !== 32'h8000_0040) begin failures++; $display("FAIL drain_pc got=%h want=80000040", rpc); end
        checks++; if (!st) begin failures++; $display("FAIL drain_stable got=0 want=1"); end
        checks++; if (!wo) begin failures++; $display("FAIL drain_wait got=0 want=1"); end
        checks++; if (switch_cnt !== 16'd2) begin failures++; $display("FAIL drain_cnt got=%0d want=2", switch_cnt); end
    endtask

    task automatic test_round_trip();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        logic [31:0] want [3] = '{32'h8000_0100, 32'h0000_0100, 32'h8000_0200};
        logic [31:0] pcs  [3] = '{32'h0000_0100, 32'h8000_0200, 32'h0000_0300};
        int          fr   [3] = '{0, 1, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            model_switch(fr[i], 1 - fr[i], pcs[i], 0, -1, 0, 0, epc, ev);
            drive_switch(fr[i], 1 - fr[i], pcs[i], 0, 0, -1, 0, 0, 0, v, rpc, st, wo);
            checks++; if (rpc !== want[i]) begin failures++; $display("FAIL round_trip_pc%0d got=%h want=%h", i, rpc, want[i]); end
        end
        checks++; if (switch_cnt !== 16'd3) begin failures++; $display("FAIL round_trip_cnt got=%0d want=3", switch_cnt); end
    endtask

    task automatic test_collisions();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        model_switch(0, 1, 32'h44, 0, 0, 0, 32'hAAAA_0000, epc, ev);
        drive_switch(0, 1, 32'h44, 0, 0, 0, 0, 32'hAAAA_0000, 0, v, rpc, st, wo);
        checks++; if (dut.u_regfile.bank_q[0] !== 32'h44) begin failures++; $display("FAIL coll_capture_wins got=%h want=44", dut.u_regfile.bank_q[0]); end
        model_switch(1, 0, 32'h50, 0, -1, 0, 0, epc, ev);
        drive_switch(1, 0, 32'h50, 0, 0, -1, 0, 0, 0, v, rpc, st, wo);
        model_switch(0, 1, 32'h60, 0, 1, 1, 32'h1235, epc, ev);
        drive_switch(0, 1, 32'h60, 0, 0, 1, 1, 32'h1235, 0, v, rpc, st, wo);
        checks++; if (rpc !== 32'h1234) begin failures++; $display("FAIL coll_forward got=%h want=1234", rpc); end
        checks++; if (dut.u_regfile.bank_q[1] !== 32'h1234) begin failures++; $display("FAIL coll_bank1 got=%h want=1234", dut.u_regfile.bank_q[1]); end
        // write lands while the redirect is being offered
        model_switch(1, 0, 32'h70, 0, 2, 0, 32'hBEEF1, epc, ev);
        drive_switch(1, 0, 32'h70, 0, 2, 2, 0, 32'hBEEF1, 0, v, rpc, st, wo);
        checks++; if (rpc !== 32'h60) begin failures++; $display("FAIL coll_redirect_hold got=%h want=60", rpc); end
        checks++; if (dut.u_regfile.bank_q[0] !== 32'hBEEF0) begin failures++; $display("FAIL coll_redirect_bank got=%h want=beef0", dut.u_regfile.bank_q[0]); end
    endtask

    task automatic test_illegal();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        model_switch(0, 1, 32'h0000_0a00, 3, -1, 0, 0, epc, ev);
        drive_switch(0, 1, 32'h0000_0a00, 3, 0, -1, 0, 0, 1, v, rpc, st, wo);
        checks++; if (v != ev) begin failures++; $display("FAIL illegal_latency got=%0d want=%0d", v, ev); end
        checks++; if (rpc !== epc) begin failures++; $display("FAIL illegal_pc got=%h want=%h", rpc, epc); end
        checks++; if (dut.u_regfile.bank_q[0] !== bank_m[0] || dut.u_regfile.bank_q[1] !== bank_m[1]) begin
            failures++; $display("FAIL illegal_bank got=%h/%h want=%h/%h", dut.u_regfile.bank_q[0], dut.u_regfile.bank_q[1], bank_m[0], bank_m[1]);
        end
        checks++; if (switch_cnt !== 16'(cnt_m)) begin failures++; $display("FAIL illegal_cnt got=%0d want=%0d", switch_cnt, cnt_m); end
    endtask

    task automatic test_reset_mid();
        bus.thread_sel = 2'b01; bus.thread_sel_next = 2'b10;
        bus.ifu_cur_pc = 32'h0000_0c00; bus.switch_en = 1'b1;
        bus.ifu_rsp_pending = 1'b0; bus.redirect_rdy = 1'b0;
        @(negedge clk); bus.switch_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.redirect_vld !== 1'b1) begin failures++; $display("FAIL rstmid_pre_vld got=%b want=1", bus.redirect_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.redirect_vld !== 1'b0) begin failures++; $display("FAIL rstmid_vld got=%b want=0", bus.redirect_vld); end
        checks++; if (bus.ifetch_wait !== 1'b0) begin failures++; $display("FAIL rstmid_wait got=%b want=0", bus.ifetch_wait); end
        checks++; if (switch_cnt !== 16'h0) begin failures++; $display("FAIL rstmid_cnt got=%0d want=0", switch_cnt); end
        checks++; if (dut.u_regfile.bank_q[1] !== BOOT1) begin failures++; $display("FAIL rstmid_bank1 got=%h want=%h", dut.u_regfile.bank_q[1], BOOT1); end
        checks++; if (dut.u_regfile.bank_q[0] !== 32'h0) begin failures++; $display("FAIL rstmid_bank0 got=%h want=0", dut.u_regfile.bank_q[0]); end
        do_reset();
    endtask

    task automatic test_saturation();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            model_switch(i % 2, 1 - (i % 2), 32'h100 * i, 0, -1, 0, 0, epc, ev);
            drive_switch(i % 2, 1 - (i % 2), 32'h100 * i, 0, 0, -1, 0, 0, 0, v, rpc, st, wo);
            checks++; if (int'(switch_cnt_s) != ((cnt_m > 3) ? 3 : cnt_m)) begin
                failures++; $display("FAIL sat_cnt%0d got=%0d want=%0d", i, switch_cnt_s, (cnt_m > 3) ? 3 : cnt_m);
            end
        end
        checks++; if (switch_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide_cnt got=%0d want=5", switch_cnt); end
    endtask

    task automatic test_random();
        int v; logic [31:0] rpc, epc; bit st, wo; int ev;
        int from, to, pend, stall, wr_at, wr_tid; logic [31:0] pc, wd;
        for (int i = 0; i < 24; i++) begin
            from = $urandom_range(1, 0); to = $urandom_range(1, 0);
            pc = $urandom; wd = $urandom;
            pend = $urandom_range(4, 0); stall = $urandom_range(3, 0);
            wr_tid = $urandom_range(1, 0);
            wr_at = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(((pend > 1) ? pend : 1) + 1, 0));
            model_switch(from, to, pc, pend, wr_at, wr_tid, wd, epc, ev);
            drive_switch(from, to, pc, pend, stall, wr_at, wr_tid, wd, 0, v, rpc, st, wo);
            checks++; if (v != ev) begin failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, v, ev); end
            checks++; if (rpc !== epc) begin failures++; $display("FAIL rand%0d_pc got=%h want=%h", i, rpc, epc); end
            checks++; if (!st || !wo) begin failures++; $display("FAIL rand%0d_hold got=%b%b want=11", i, st, wo); end
            checks++; if (dut.u_regfile.bank_q[0] !== bank_m[0] || dut.u_regfile.bank_q[1] !== bank_m[1]) begin
                failures++; $display("FAIL rand%0d_bank got=%h/%h want=%h/%h", i, dut.u_regfile.bank_q[0], dut.u_regfile.bank_q[1], bank_m[0], bank_m[1]);
            end
            checks++; if (switch_cnt !== 16'(cnt_m)) begin failures++; $display("FAIL rand%0d_cnt got=%0d want=%0d", i, switch_cnt, cnt_m); end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_drain_backpressure();
        test_round_trip();
        test_collisions();
        test_illegal();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
